// File: rtl/wb_commit_unit.sv
// Write-back commit stage: sole driver of the register-file write port, load alignment, load scoreboard.
// Optional retire counter output enabled by defining WB_RETIRE_CNT_EN.
module wb_commit_unit #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int REGW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [REGW-1:0] alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  input  logic [REGW-1:0] ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] ld_rdata,
  input  logic            iss_valid,
  input  logic [REGW-1:0] iss_rd,
  input  logic [REGW-1:0] chk_rs1,
  input  logic [REGW-1:0] chk_rs2,
  input  logic [REGW-1:0] chk_rd,
  output logic            hazard,
`ifdef WB_RETIRE_CNT_EN
  output logic [63:0]     retire_cnt,
`endif
  output logic            rf_en,
  output logic [REGW-1:0] rf_rd,
  output logic [XLEN-1:0] rf_data,
  output logic            ld_err
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic            rf_en_q,   rf_en_d;
  logic [REGW-1:0] rf_rd_q,   rf_rd_d;
  logic [XLEN-1:0] rf_data_q, rf_data_d;
  logic            ld_err_q,  ld_err_d;
  logic [NREG-1:0] busy_q,    busy_d;

  logic            alu_acc;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] ld_aligned;
  logic            ld_bad;

  assign alu_ready = !ld_valid;
  assign alu_acc   = alu_valid && !ld_valid;

  always_comb begin
    byte_sel = ld_rdata[7:0];
    case (ld_off)
      2'd0: byte_sel = ld_rdata[7:0];
      2'd1: byte_sel = ld_rdata[15:8];
      2'd2: byte_sel = ld_rdata[23:16];
      2'd3: byte_sel = ld_rdata[31:24];
      default: byte_sel = ld_rdata[7:0];
    endcase
    half_sel = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
  end

  always_comb begin
    ld_aligned = '0;
    ld_bad     = 1'b0;
    case (ld_funct3)
      F3_LB:  ld_aligned = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU: ld_aligned = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH: begin
        ld_aligned = {{(XLEN-16){half_sel[15]}}, half_sel};
        ld_bad     = ld_off[0];
      end
      F3_LHU: begin
        ld_aligned = {{(XLEN-16){1'b0}}, half_sel};
        ld_bad     = ld_off[0];
      end
      F3_LW: begin
        ld_aligned = ld_rdata;
        ld_bad     = (ld_off != 2'd0);
      end
      default: ld_bad = 1'b1;
    endcase
  end

  // rf_rd/rf_data only move when a real write happens; otherwise they hold.
  always_comb begin
    rf_en_d   = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    ld_err_d  = 1'b0;
    if (ld_valid) begin
      if (ld_bad) begin
        ld_err_d = 1'b1;
      end else if (ld_rd != '0) begin
        rf_en_d   = 1'b1;
        rf_rd_d   = ld_rd;
        rf_data_d = ld_aligned;
      end
    end else if (alu_acc && (alu_rd != '0)) begin
      rf_en_d   = 1'b1;
      rf_rd_d   = alu_rd;
      rf_data_d = alu_data;
    end
  end

  // Clear is applied before set so a same-cycle issue to the same rd stays busy.
  always_comb begin
    busy_d = busy_q;
    if (ld_valid) begin
      busy_d[ld_rd] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  assign hazard = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[chk_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_en_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
      ld_err_q  <= 1'b0;
      busy_q    <= '0;
    end else begin
      rf_en_q   <= rf_en_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      ld_err_q  <= ld_err_d;
      busy_q    <= busy_d;
    end
  end

  assign rf_en   = rf_en_q;
  assign rf_rd   = rf_rd_q;
  assign rf_data = rf_data_q;
  assign ld_err  = ld_err_q;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q, retire_cnt_d;

  // Every accepted commit retires, including x0 and faulting loads.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (ld_valid || alu_acc) begin
      retire_cnt_d = retire_cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit: vector table for commit/align paths, hand sequences for scoreboard and reset.
module tb_wb_commit_unit;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;
  logic [31:0] ld_rdata;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic [4:0]  chk_rd;
  logic        hazard;
  logic        rf_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        ld_err;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  int n_checks;
  int n_fail;

  wb_commit_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_rd     (ld_rd),
    .ld_funct3 (ld_funct3),
    .ld_off    (ld_off),
    .ld_rdata  (ld_rdata),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .chk_rd    (chk_rd),
    .hazard    (hazard),
`ifdef WB_RETIRE_CNT_EN
    .retire_cnt(retire_cnt),
`endif
    .rf_en     (rf_en),
    .rf_rd     (rf_rd),
    .rf_data   (rf_data),
    .ld_err    (ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        alu_v;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        ld_v;
    logic [4:0]  l_rd;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic        e_ready;
    logic        e_en;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_err;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_valid  = 1'b0; ld_rd  = 5'd0; ld_funct3 = 3'b010; ld_off = 2'd0; ld_rdata = 32'd0;
    iss_valid = 1'b0; iss_rd = 5'd0;
  endtask

  task automatic do_alu(input logic [4:0] rd, input logic [31:0] d);
    idle_inputs();
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
  endtask

  task automatic do_ld(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                       input logic [31:0] d);
    idle_inputs();
    ld_valid = 1'b1; ld_rd = rd; ld_funct3 = f3; ld_off = off; ld_rdata = d;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle_inputs();
    chk_rs1 = 5'd5; chk_rs2 = 5'd6; chk_rd = 5'd7;

    //           alu_v a_rd   a_data         ld_v  l_rd   f3      off    rdata           rdy   en    e_rd   e_data         err
    vecs[0]  = '{1'b1, 5'd5,  32'h0000_1234, 1'b0, 5'd0,  3'b000, 2'd0, 32'h0,          1'b1, 1'b1, 5'd5,  32'h0000_1234, 1'b0};
    vecs[1]  = '{1'b1, 5'd6,  32'h0000_0055, 1'b1, 5'd7,  3'b010, 2'd0, 32'hDEAD_BEEF, 1'b0, 1'b1, 5'd7,  32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 5'd6,  32'h0000_0055, 1'b0, 5'd0,  3'b000, 2'd0, 32'h0,          1'b1, 1'b1, 5'd6,  32'h0000_0055, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd10, 3'b000, 2'd3, 32'h80FF_00AA, 1'b0, 1'b1, 5'd10, 32'hFFFF_FF80, 1'b0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd11, 3'b100, 2'd3, 32'h80FF_00AA, 1'b0, 1'b1, 5'd11, 32'h0000_0080, 1'b0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd12, 3'b101, 2'd2, 32'h80FF_00AA, 1'b0, 1'b1, 5'd12, 32'h0000_80FF, 1'b0};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd13, 3'b001, 2'd2, 32'h80FF_00AA, 1'b0, 1'b1, 5'd13, 32'hFFFF_80FF, 1'b0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd14, 3'b001, 2'd0, 32'h80FF_00AA, 1'b0, 1'b1, 5'd14, 32'h0000_00AA, 1'b0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd15, 3'b000, 2'd0, 32'h80FF_00AA, 1'b0, 1'b1, 5'd15, 32'hFFFF_FFAA, 1'b0};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd16, 3'b100, 2'd1, 32'h80FF_00AA, 1'b0, 1'b1, 5'd16, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd17, 3'b001, 2'd1, 32'h80FF_00AA, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1};
    vecs[11] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd18, 3'b010, 2'd2, 32'h80FF_00AA, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1};
    vecs[12] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd19, 3'b011, 2'd0, 32'h80FF_00AA, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1};
    vecs[13] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd20, 3'b101, 2'd3, 32'h80FF_00AA, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1};
    vecs[14] = '{1'b1, 5'd0,  32'hCAFE_0001, 1'b0, 5'd0,  3'b000, 2'd0, 32'h0,          1'b1, 1'b0, 5'd0,  32'h0,         1'b0};
    vecs[15] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  3'b010, 2'd0, 32'h1111_2222, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0};
    vecs[16] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  3'b010, 2'd0, 32'h0,          1'b1, 1'b0, 5'd0,  32'h0,         1'b0};

    // Reset state
    tick();
    tick();
    check("reset_rf_en",   {63'd0, rf_en},   64'd0);
    check("reset_rf_rd",   {59'd0, rf_rd},   64'd0);
    check("reset_rf_data", {32'd0, rf_data}, 64'd0);
    check("reset_ld_err",  {63'd0, ld_err},  64'd0);
    check("reset_hazard",  {63'd0, hazard},  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Vector table: commit path, priority, alignment, errors, x0
    for (int i = 0; i < NVEC; i++) begin
      idle_inputs();
      alu_valid = vecs[i].alu_v; alu_rd = vecs[i].a_rd; alu_data = vecs[i].a_data;
      ld_valid = vecs[i].ld_v; ld_rd = vecs[i].l_rd; ld_funct3 = vecs[i].f3;
      ld_off = vecs[i].off; ld_rdata = vecs[i].rdata;
      #1;
      check($sformatf("v%0d_alu_ready", i), {63'd0, alu_ready}, {63'd0, vecs[i].e_ready});
      tick();
      check($sformatf("v%0d_rf_en", i), {63'd0, rf_en}, {63'd0, vecs[i].e_en});
      check($sformatf("v%0d_ld_err", i), {63'd0, ld_err}, {63'd0, vecs[i].e_err});
      if (vecs[i].e_en) begin
        check($sformatf("v%0d_rf_rd", i), {59'd0, rf_rd}, {59'd0, vecs[i].e_rd});
        check($sformatf("v%0d_rf_data", i), {32'd0, rf_data}, {32'd0, vecs[i].e_data});
      end
    end
    idle_inputs();
    tick();
    check("idle_rf_en", {63'd0, rf_en}, 64'd0);

    // Scoreboard: issue rd=9, hazard visible only after the edge
    chk_rs1 = 5'd1; chk_rs2 = 5'd9; chk_rd = 5'd2;
    iss_valid = 1'b1; iss_rd = 5'd9;
    #1;
    check("sb_pre_update", {63'd0, hazard}, 64'd0);
    tick();
    idle_inputs();
    #1;
    check("sb_busy_rs2", {63'd0, hazard}, 64'd1);
    chk_rs2 = 5'd3; chk_rd = 5'd9;
    #1;
    check("sb_busy_rd", {63'd0, hazard}, 64'd1);
    chk_rs2 = 5'd9; chk_rd = 5'd2;
    do_ld(5'd9, 3'b010, 2'd0, 32'h0000_0009);
    #1;
    check("sb_clear_pre", {63'd0, hazard}, 64'd1);
    tick();
    idle_inputs();
    #1;
    check("sb_cleared", {63'd0, hazard}, 64'd0);

    // Same-cycle issue and completion on rd=9: set wins
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    do_ld(5'd9, 3'b010, 2'd0, 32'h0000_0019);
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    idle_inputs();
    #1;
    check("sb_set_wins", {63'd0, hazard}, 64'd1);
    do_ld(5'd9, 3'b010, 2'd0, 32'h0000_0029);
    tick();
    idle_inputs();
    #1;
    check("sb_final_clear", {63'd0, hazard}, 64'd0);

    // x0 never becomes busy
    chk_rs1 = 5'd0; chk_rs2 = 5'd0; chk_rd = 5'd0;
    iss_valid = 1'b1; iss_rd = 5'd0;
    tick();
    idle_inputs();
    #1;
    check("sb_x0_never_busy", {63'd0, hazard}, 64'd0);

    // Reset mid-burst with busy[3]=1 and a commit on the outputs
    chk_rs1 = 5'd3; chk_rs2 = 5'd0; chk_rd = 5'd0;
    do_alu(5'd4, 32'h0000_0077);
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick();
    do_alu(5'd4, 32'h0000_0078);
    #1;
    check("rst_pre_busy", {63'd0, hazard}, 64'd1);
    check("rst_pre_rf_en", {63'd0, rf_en}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_rf_en", {63'd0, rf_en}, 64'd0);
    check("rst_async_hazard", {63'd0, hazard}, 64'd0);
    check("rst_async_rf_data", {32'd0, rf_data}, 64'd0);
    idle_inputs();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_hazard", {63'd0, hazard}, 64'd0);

`ifdef WB_RETIRE_CNT_EN
    check("retire_after_reset", retire_cnt, 64'd0);
    for (int k = 0; k < 3; k++) begin
      do_alu(5'(k + 1), 32'(k));
      tick();
    end
    do_ld(5'd8, 3'b001, 2'd1, 32'h1234_5678);
    tick();
    idle_inputs();
    tick();
    check("retire_cnt_4", retire_cnt, 64'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
